// File: rtl/str_esc_pkg.sv
// Shared constants and character helpers for the string-literal escape decoder.
// State codes are plain localparams so they can be compared and stored without enum casts.
package str_esc_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ESC  = 3'd1;
  localparam logic [2:0] ST_OCT1 = 3'd2;
  localparam logic [2:0] ST_OCT2 = 3'd3;
  localparam logic [2:0] ST_HEX0 = 3'd4;
  localparam logic [2:0] ST_HEX1 = 3'd5;
  localparam logic [2:0] ST_TAIL = 3'd6;

  typedef logic [2:0] state_t;

  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_X      = 8'h78;
  localparam logic [7:0] CH_DQUOTE = 8'h22;
  localparam logic [7:0] CH_N      = 8'h6E;
  localparam logic [7:0] CH_T      = 8'h74;
  localparam logic [7:0] CH_A      = 8'h61;
  localparam logic [7:0] CH_F      = 8'h66;
  localparam logic [7:0] CH_V      = 8'h76;

  localparam logic [7:0] VAL_NL  = 8'h0A;
  localparam logic [7:0] VAL_TAB = 8'h09;
  localparam logic [7:0] VAL_BEL = 8'h07;
  localparam logic [7:0] VAL_FF  = 8'h0C;
  localparam logic [7:0] VAL_VT  = 8'h0B;

  function automatic logic is_octal(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h37);
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Non-hex bytes map to zero; callers gate on is_hex.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] v;
    v = 8'h00;
    if ((c >= 8'h30) && (c <= 8'h39)) v = c - 8'h30;
    else if ((c >= 8'h41) && (c <= 8'h46)) v = c - 8'h37;
    else if ((c >= 8'h61) && (c <= 8'h66)) v = c - 8'h57;
    return v[3:0];
  endfunction

endpackage

// File: rtl/str_esc_classify.sv
// Combinational byte classifier: digit tests, digit value and the single-character escape map.
module str_esc_classify
  import str_esc_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_oct_o,
  output logic       is_hex_o,
  output logic [3:0] digit_o,
  output logic       simple_hit_o,
  output logic [7:0] simple_val_o
);

  assign is_oct_o = is_octal(byte_i);
  assign is_hex_o = is_hex(byte_i);
  assign digit_o  = hex_val(byte_i);

  always_comb begin
    simple_hit_o = 1'b1;
    simple_val_o = 8'h00;
    case (byte_i)
      CH_N:      simple_val_o = VAL_NL;
      CH_T:      simple_val_o = VAL_TAB;
      CH_BSLASH: simple_val_o = CH_BSLASH;
      CH_DQUOTE: simple_val_o = CH_DQUOTE;
      CH_A:      simple_val_o = VAL_BEL;
      CH_F:      simple_val_o = VAL_FF;
      CH_V:      simple_val_o = VAL_VT;
      default:   simple_hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/str_escape_decoder.sv
// Streaming decoder for string-literal bodies: one raw byte in per cycle, decoded bytes out
// through a single registered output slot, plus a per-literal decoded length report.
module str_escape_decoder
  import str_esc_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             err,
  output logic             len_valid,
  output logic [LEN_W-1:0] len
);

  state_t           state_q, state_d;
  state_t           tail_q, tail_d;
  logic [8:0]       acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;
  logic             len_valid_q, len_valid_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic       c_oct, c_hex, c_simple;
  logic [3:0] c_digit;
  logic [7:0] c_simple_val;

  str_esc_classify u_classify (
    .byte_i       (in_data),
    .is_oct_o     (c_oct),
    .is_hex_o     (c_hex),
    .digit_o      (c_digit),
    .simple_hit_o (c_simple),
    .simple_val_o (c_simple_val)
  );

  logic             slot_free, flush_cond, hex_bad, ready_c, consume;
  logic             emit, emit_last;
  logic [7:0]       emit_data;
  state_t           nxt;
  logic [8:0]       oct_next, hex_next;
  logic [LEN_W-1:0] cnt_inc;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    // A non-digit ending a numeric escape is held back while the partial value drains.
    flush_cond = (((state_q == ST_OCT1) || (state_q == ST_OCT2)) && !c_oct) ||
                 ((state_q == ST_HEX1) && !c_hex);
    hex_bad    = (state_q == ST_HEX0) && !c_hex;
    ready_c    = !reset && (state_q != ST_TAIL) && slot_free && !flush_cond && !hex_bad;
    consume    = in_valid && ready_c;
    oct_next   = (acc_q << 3) | {6'b0, c_digit[2:0]};
    hex_next   = (acc_q << 4) | {5'b0, c_digit};

    state_d   = state_q;
    tail_d    = tail_q;
    acc_d     = acc_q;
    emit      = 1'b0;
    emit_data = 8'h00;
    emit_last = 1'b0;
    err_d     = 1'b0;
    nxt       = ST_IDLE;

    if (state_q == ST_TAIL) begin
      if (slot_free) begin
        emit      = 1'b1;
        emit_last = 1'b1;
        state_d   = ST_IDLE;
        case (tail_q)
          ST_ESC:  begin emit_data = CH_BSLASH; err_d = 1'b1; end
          ST_HEX0: begin emit_data = CH_X;      err_d = 1'b1; end
          default: emit_data = acc_q[7:0];
        endcase
      end
    end else if (in_valid && flush_cond && slot_free) begin
      emit      = 1'b1;
      emit_data = acc_q[7:0];
      state_d   = ST_IDLE;
    end else if (in_valid && hex_bad) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (consume) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == CH_BSLASH) nxt = ST_ESC;
          else begin emit = 1'b1; emit_data = in_data; end
        end
        ST_ESC: begin
          if (c_simple) begin emit = 1'b1; emit_data = c_simple_val; end
          else if (c_oct) begin acc_d = {5'b0, c_digit}; nxt = ST_OCT1; end
          else if (in_data == CH_X) nxt = ST_HEX0;
          else begin emit = 1'b1; emit_data = in_data; end
        end
        ST_OCT1: begin acc_d = oct_next; nxt = ST_OCT2; end
        ST_OCT2: begin emit = 1'b1; emit_data = oct_next[7:0]; end
        ST_HEX0: begin acc_d = {5'b0, c_digit}; nxt = ST_HEX1; end
        ST_HEX1: begin emit = 1'b1; emit_data = hex_next[7:0]; end
        default: nxt = ST_IDLE;
      endcase
      // A literal ending inside an escape still owes one byte, sent from TAIL.
      if (in_last && (nxt != ST_IDLE)) begin
        state_d = ST_TAIL;
        tail_d  = nxt;
      end else begin
        state_d   = nxt;
        emit_last = in_last;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    len_valid_d = 1'b0;
    len_d       = len_q;
    cnt_d       = cnt_q;
    cnt_inc     = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_last_d  = emit_last;
      if (emit_last) begin
        len_d       = cnt_inc;
        len_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tail_q      <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      len_valid_q <= 1'b0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      tail_q      <= tail_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      len_valid_q <= len_valid_d;
      len_q       <= len_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign len_valid = len_valid_q;
  assign len       = len_q;

endmodule

// File: tb/tb_str_escape_decoder.sv
// Directed bench for str_escape_decoder: feeds literal bodies byte by byte and compares the
// decoded stream, length report and error pulses against hand-computed values.
module tb_str_escape_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        err;
  logic        len_valid;
  logic [15:0] len;

  str_escape_decoder #(.LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err),
    .len_valid (len_valid),
    .len       (len)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [8:0] got_q[$];
  int         err_cnt, lenv_cnt, stall_in_cnt;
  logic [15:0] len_seen;
  bit         rnd_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_out;
  bit         accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    got_q.delete();
    err_cnt = 0;
    lenv_cnt = 0;
    stall_in_cnt = 0;
    len_seen = 16'h0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge; samples everything just after it.
  task automatic step();
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (prev_stall) check("stall_hold", {23'b0, out_valid, out_last, out_data}, {23'b0, 1'b1, prev_out});
    prev_stall = out_valid && !out_ready;
    prev_out = {out_last, out_data};
    if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    if (err) err_cnt++;
    if (len_valid) begin
      lenv_cnt++;
      len_seen = len;
    end
    if (in_valid && !in_ready) stall_in_cnt++;
    accepted = in_valid && in_ready;
    @(negedge clk);
  endtask

  task automatic feed(input string s, input bit with_last);
    int w;
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_data = s[i];
      in_last = with_last && (i == s.len() - 1);
      w = 0;
      accepted = 1'b0;
      while (!accepted && w < 50) begin
        step();
        w++;
      end
      if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
  endtask

  task automatic run_lit(input string tag, input string s, input logic [63:0] exp_v,
                         input int n, input int exp_err);
    int w;
    logic [7:0] eb;
    clear();
    feed(s, 1'b1);
    w = 0;
    while (!(got_q.size() > 0 && got_q[got_q.size()-1][8]) && w < 60) begin
      step();
      w++;
    end
    step();
    step();
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      eb = exp_v[8*(n-1-i) +: 8];
      if (i < got_q.size())
        check($sformatf("%s_b%0d", tag, i), {23'b0, got_q[i]}, {23'b0, (i == n-1), eb});
    end
    check({tag, "_len"}, {16'b0, len_seen}, n);
    check({tag, "_lenv"}, lenv_cnt, 1);
    check({tag, "_err"}, err_cnt, exp_err);
    $display("lit %s: bytes=%0d len=%0d err=%0d", tag, got_q.size(), len_seen, err_cnt);
  endtask

  initial begin
    clear();
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_err_lenv", {30'b0, err, len_valid}, 0);
    check("rst_len", {16'b0, len}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    run_lit("ab", "ab", 64'h6162, 2, 0);
    check("ab_in_stall", stall_in_cnt, 0);

    run_lit("simple", "\\n\\t\\\\\\\"\\a\\f\\v\\q", 64'h0A09_5C22_070C_0B71, 8, 0);

    run_lit("octal", "\\101\\7z\\777", 64'h4107_7AFF, 4, 0);
    check("octal_flush_stall", stall_in_cnt, 1);

    run_lit("hex_bad", "\\x4g\\xZ", 64'h04_675A, 3, 1);

    run_lit("tail_bs", "\\", 64'h5C, 1, 1);
    run_lit("tail_oct", "\\12", 64'h0A, 1, 0);
    run_lit("tail_x", "\\x", 64'h78, 1, 1);

    rnd_ready = 1'b1;
    run_lit("stall_hex", "\\x41B", 64'h4142, 2, 0);
    rnd_ready = 1'b0;
    repeat (3) step();

    clear();
    feed("\\x4", 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    run_lit("after_rst", "c", 64'h63, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/str_escape_decoder.md
Name: str_escape_decoder

Overview:
- Streaming decoder for SystemVerilog string-literal bodies. Takes raw source bytes (no enclosing quotes) and emits the decoded character values per IEEE 1800 escape rules.
- Sits between the lexer's literal-capture buffer and the literal-to-vector packer. Sequences one input byte per cycle through an escape FSM under valid/ready flow control on both sides.
- Also reports the decoded length of each literal.

Parameters:
- LEN_W, 16, width of the decoded-length counter. Saturates at 2**LEN_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid && in_ready
- in_data  in  8  raw literal byte
- in_last  in  1  final byte of the current literal
- out_valid  out  1  decoded byte valid (registered)
- out_ready  in  1  downstream accepts
- out_data  out  8  decoded byte
- out_last  out  1  final decoded byte of the literal
- err  out  1  one-cycle pulse on a malformed \x escape
- len_valid  out  1  one-cycle pulse; len holds the byte count of the literal just completed
- len  out  LEN_W  decoded byte count, including the out_last byte

Behaviour:
- Reset: state=IDLE, acc=0, cnt=0. All outputs are 0; in_ready may go high the cycle after reset deasserts.
- Output register: the slot is free when !out_valid || out_ready. A byte is consumed only if the slot is free and the FSM is not flushing. Decode latency is 1 cycle from consume to out_valid.
- States: IDLE, ESC, OCT1, OCT2, HEX0, HEX1, TAIL.
- IDLE:
  - A byte other than '\' is emitted unchanged.
  - '\' goes to ESC and emits nothing.
- ESC:
  - n->0x0A, t->0x09, '\'->0x5C, '"'->0x22, a->0x07, f->0x0C, v->0x0B; all emit and return to IDLE.
  - Octal digit 0-7: acc=digit, go to OCT1.
  - 'x': go to HEX0.
  - Any other byte (including 8, 9, uppercase, punctuation, space) is emitted as itself, e.g. "\q" gives 0x71.
- OCT1: an octal digit sets acc=acc*8+d and goes to OCT2. Otherwise flush.
- OCT2: an octal digit emits (acc*8+d)[7:0] and returns to IDLE. Otherwise flush. acc is 9 bits: \777 gives 0xFF, \400 gives 0x00.
- HEX0:
  - Hex digit (0-9, a-f, A-F): acc=value, go to HEX1.
  - Otherwise: err pulse, nothing emitted, byte not consumed, return to IDLE.
- HEX1: a hex digit emits acc*16+d and returns to IDLE. Otherwise flush.
- Flush: in_ready=0 that cycle and the byte is not consumed. acc[7:0] is emitted with out_last=0 and the state returns to IDLE. The held byte is processed next cycle, keeping its own in_last.
- in_last consumed while the resulting state is not IDLE: go to TAIL and set in_ready=0 until the tail byte is emitted. The tail byte carries out_last=1:
  - from OCT1, OCT2 or HEX1: emits acc[7:0];
  - from ESC (trailing lone '\'): emits 0x5C and pulses err;
  - from HEX0 (trailing "\x"): emits 0x78 and pulses err.
- Otherwise, out_last=1 accompanies the byte emitted from the in_last input.
- Length:
  - cnt increments on each emitted byte and saturates.
  - When the out_last byte is loaded, len=cnt+1 (saturated), len_valid pulses in that same cycle, and cnt clears.
- Backpressure: out_data and out_last hold stable while out_valid && !out_ready.
- Reset mid-literal discards acc, the pending byte and cnt.

Decomposition:
- Package str_esc_pkg holds:
  - the state enum;
  - character constants (CH_BSLASH, CH_X, escape map values);
  - functions is_octal, is_hex, hex_val.
- One natural combinational sub-module: str_esc_classify (byte -> is_octal, is_hex, digit value, simple-escape hit and mapped value).

Test Plan:
- "ab" with last on 'b', out_ready=1 -> 0x61, 0x62 (last=1) on consecutive cycles; len=2, len_valid pulse, err never set.
- "\n\t\\\"\a\f\v\q" -> 0x0A 0x09 0x5C 0x22 0x07 0x0C 0x0B 0x71; len=8.
- "\101\7z\777" -> 0x41, 0x07, 0x7A, 0xFF (last). in_ready is low for exactly one cycle at 'z' (the flush).
- "\x4g\xZ" -> 0x04, 0x67, err pulse at 'Z', then 0x5A (last); len=3.
- Trailing "\" with last -> 0x5C, out_last=1, err=1. Trailing "\12" with last -> 0x0A via TAIL, out_last=1.
- out_ready toggled randomly on "\x41B" -> data stable under stall; sequence 0x41, 0x42; no byte lost or duplicated. Reset asserted mid-escape -> next literal "c" gives 0x63, len=1.
